// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: phase encoding, lamp bundles
// and an elaboration-time parameter legality check.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_NS_G = 3'd0,
    S_NS_Y = 3'd1,
    S_AR_A = 3'd2,
    S_EW_G = 3'd3,
    S_EW_Y = 3'd4,
    S_AR_B = 3'd5
  } phase_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  typedef struct packed {
    lamp_t ns;
    lamp_t ew;
  } lamps_t;

  localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

  function automatic lamps_t decode_lamps(input phase_t p);
    lamps_t l;
    l.ns = LAMP_RED;
    l.ew = LAMP_RED;
    case (p)
      S_NS_G:  l.ns = LAMP_GREEN;
      S_NS_Y:  l.ns = LAMP_YELLOW;
      S_EW_G:  l.ew = LAMP_GREEN;
      S_EW_Y:  l.ew = LAMP_YELLOW;
      default: ;
    endcase
    return l;
  endfunction

  function automatic bit params_legal(input int ns_g, input int ew_g, input int yel,
                                      input int ar, input int min_g, input int cnt_w);
    int mx;
    mx = ns_g;
    if (ew_g > mx) mx = ew_g;
    if (yel > mx) mx = yel;
    if (ar > mx) mx = ar;
    return (min_g >= 1) && (min_g <= ns_g) && (min_g <= ew_g) &&
           (yel >= 1) && (ar >= 1) && (cnt_w >= 1) && (cnt_w < 31) &&
           ((1 << cnt_w) > mx);
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Bundle of tick, detector, lamp and debug signals between the controller
// (slave) and its environment (master).
interface traffic_phase_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             tick;
  logic             NS_VEHICLE_DETECT;
  logic             EW_VEHICLE_DETECT;
  logic             NS_RED;
  logic             NS_YELLOW;
  logic             NS_GREEN;
  logic             EW_RED;
  logic             EW_YELLOW;
  logic             EW_GREEN;
  logic [2:0]       phase;
  logic [CNT_W-1:0] elapsed;

  modport master (
    output tick, NS_VEHICLE_DETECT, EW_VEHICLE_DETECT,
    input  NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN, phase, elapsed
  );

  modport slave (
    input  tick, NS_VEHICLE_DETECT, EW_VEHICLE_DETECT,
    output NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN, phase, elapsed
  );
endinterface

// File: rtl/phase_timer.sv
// Shared phase timer: counts ticks since the last clear, saturating at limit.
module phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick_en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] elapsed
);

  logic [CNT_W-1:0] elapsed_reg;
  logic [CNT_W-1:0] elapsed_next;

  always_comb begin
    elapsed_next = elapsed_reg;
    if (clear) begin
      elapsed_next = '0;
    end else if (tick_en && (elapsed_reg < limit)) begin
      elapsed_next = elapsed_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed_reg <= '0;
    end else begin
      elapsed_reg <= elapsed_next;
    end
  end

  assign elapsed = elapsed_reg;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Self-timed NS/EW phase controller with min-green, gap-out, latched EW
// requests and all-red clearance; lamps are registered from the next state.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NS_GREEN_T  = 32,
  parameter int EW_GREEN_T  = 16,
  parameter int YELLOW_T    = 4,
  parameter int ALLRED_T    = 1,
  parameter int MIN_GREEN_T = 4,
  parameter int CNT_W       = 6
) (
  input logic                clk,
  input logic                rst_n,
  traffic_phase_ctrl_if.slave bus
);

  generate
    if (!params_legal(NS_GREEN_T, EW_GREEN_T, YELLOW_T, ALLRED_T, MIN_GREEN_T, CNT_W)) begin : g_bad_params
      $error("traffic_phase_ctrl: illegal timing parameters");
    end
  endgenerate

  // Compare against e1 at CNT_W+1 bits so a saturated counter cannot wrap.
  localparam logic [CNT_W:0]   NS_GREEN_E = (CNT_W+1)'(NS_GREEN_T);
  localparam logic [CNT_W:0]   EW_GREEN_E = (CNT_W+1)'(EW_GREEN_T);
  localparam logic [CNT_W:0]   YELLOW_E   = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0]   ALLRED_E   = (CNT_W+1)'(ALLRED_T);
  localparam logic [CNT_W:0]   MIN_E      = (CNT_W+1)'(MIN_GREEN_T);
  localparam logic [CNT_W-1:0] NS_SAT     = CNT_W'(NS_GREEN_T);

  phase_t           state_reg, state_next;
  logic             ew_req_reg, ew_req_next;
  lamps_t           lamps_reg;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W:0]   e1;
  logic             req;
  logic             timer_clear;
  logic [CNT_W-1:0] timer_limit;

  assign e1  = {1'b0, elapsed} + 1'b1;
  assign req = ew_req_reg | bus.EW_VEHICLE_DETECT;

  always_comb begin
    state_next  = state_reg;
    ew_req_next = ew_req_reg | bus.EW_VEHICLE_DETECT;
    timer_limit = (state_reg == S_NS_G) ? NS_SAT : '1;
    if (bus.tick) begin
      case (state_reg)
        S_NS_G: if (req && ((e1 >= NS_GREEN_E) ||
                            ((e1 >= MIN_E) && !bus.NS_VEHICLE_DETECT)))
                  state_next = S_NS_Y;
        S_NS_Y: if (e1 == YELLOW_E) state_next = S_AR_A;
        S_AR_A: if (e1 == ALLRED_E) state_next = S_EW_G;
        S_EW_G: if ((e1 >= EW_GREEN_E) ||
                    ((e1 >= MIN_E) && !bus.EW_VEHICLE_DETECT))
                  state_next = S_EW_Y;
        S_EW_Y: if (e1 == YELLOW_E) state_next = S_AR_B;
        S_AR_B: if (e1 == ALLRED_E) state_next = S_NS_G;
        default: state_next = S_NS_G;
      endcase
    end
    timer_clear = (state_next != state_reg);
    // Entering EW green serves the request; clearing wins over a same-clock set.
    if (timer_clear && (state_next == S_EW_G)) ew_req_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_NS_G;
      ew_req_reg <= 1'b0;
      lamps_reg  <= decode_lamps(S_NS_G);
    end else begin
      state_reg  <= state_next;
      ew_req_reg <= ew_req_next;
      lamps_reg  <= decode_lamps(state_next);
    end
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .tick_en (bus.tick),
    .limit   (timer_limit),
    .elapsed (elapsed)
  );

  assign bus.NS_RED    = lamps_reg.ns.red;
  assign bus.NS_YELLOW = lamps_reg.ns.yellow;
  assign bus.NS_GREEN  = lamps_reg.ns.green;
  assign bus.EW_RED    = lamps_reg.ew.red;
  assign bus.EW_YELLOW = lamps_reg.ew.yellow;
  assign bus.EW_GREEN  = lamps_reg.ew.green;
  assign bus.phase     = state_reg;
  assign bus.elapsed   = elapsed;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with default parameters; expected
// phases, lamps and elapsed counts are hand-derived tick by tick.
module tb_traffic_phase_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  traffic_phase_ctrl_if #(.CNT_W(6)) bus ();

  traffic_phase_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // No two directions may be non-red at once, and each lights one lamp.
  always @(negedge clk) begin
    check("inv_one_red", 32'(bus.NS_RED | bus.EW_RED), 32'd1);
    check("inv_ns_onehot", 32'(bus.NS_RED + bus.NS_YELLOW + bus.NS_GREEN), 32'd1);
    check("inv_ew_onehot", 32'(bus.EW_RED + bus.EW_YELLOW + bus.EW_GREEN), 32'd1);
  end

  task automatic step(input int n);
    bus.tick = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic expect_state(input string tag, input int ph, input int el);
    check({tag, "_phase"}, 32'(bus.phase), 32'(ph));
    check({tag, "_elapsed"}, 32'(bus.elapsed), 32'(el));
  endtask

  // Called at a negedge; asserts reset, checks the immediate effect, releases.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_ns_green"}, 32'(bus.NS_GREEN), 32'd1);
    check({tag, "_rst_ew_red"}, 32'(bus.EW_RED), 32'd1);
    check({tag, "_rst_others"}, 32'({bus.NS_RED, bus.NS_YELLOW, bus.EW_YELLOW, bus.EW_GREEN}), 32'd0);
    expect_state({tag, "_rst"}, 0, 0);
    check({tag, "_rst_ew_req"}, 32'(dut.ew_req_reg), 32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.tick = 1'b1;
    bus.NS_VEHICLE_DETECT = 1'b0;
    bus.EW_VEHICLE_DETECT = 1'b0;
    @(negedge clk);

    // Idle: no demand, NS rests in green with elapsed saturated.
    do_reset("idle");
    for (int i = 1; i <= 100; i++) begin
      step(1);
      check("idle_ns_green", 32'(bus.NS_GREEN), 32'd1);
      check("idle_ew_red", 32'(bus.EW_RED), 32'd1);
    end
    expect_state("idle_end", 0, 32);

    // Full cycle with both detectors held high.
    do_reset("full");
    bus.NS_VEHICLE_DETECT = 1'b1;
    bus.EW_VEHICLE_DETECT = 1'b1;
    step(31); expect_state("full_t31", 0, 31);
    step(1);  expect_state("full_t32", 1, 0);
    check("full_ns_yellow", 32'(bus.NS_YELLOW), 32'd1);
    step(3);  expect_state("full_t35", 1, 3);
    step(1);  expect_state("full_t36", 2, 0);
    check("full_ar_a_red", 32'({bus.NS_RED, bus.EW_RED}), 32'd3);
    step(1);  expect_state("full_t37", 3, 0);
    check("full_ew_green", 32'(bus.EW_GREEN), 32'd1);
    step(15); expect_state("full_t52", 3, 15);
    step(1);  expect_state("full_t53", 4, 0);
    check("full_ew_yellow", 32'(bus.EW_YELLOW), 32'd1);
    step(3);  expect_state("full_t56", 4, 3);
    step(1);  expect_state("full_t57", 5, 0);
    step(1);  expect_state("full_t58", 0, 0);
    check("full_back_ns_green", 32'(bus.NS_GREEN), 32'd1);

    // Gap-out: same-clock EW pulse on tick 10, EW green for min green only.
    do_reset("gap");
    bus.NS_VEHICLE_DETECT = 1'b0;
    bus.EW_VEHICLE_DETECT = 1'b0;
    step(9); expect_state("gap_t9", 0, 9);
    bus.EW_VEHICLE_DETECT = 1'b1;
    step(1); expect_state("gap_t10", 1, 0);
    bus.EW_VEHICLE_DETECT = 1'b0;
    step(4); expect_state("gap_t14", 2, 0);
    step(1); expect_state("gap_t15", 3, 0);
    check("gap_ew_req_clr", 32'(dut.ew_req_reg), 32'd0);
    step(3); expect_state("gap_t18", 3, 3);
    step(1); expect_state("gap_t19", 4, 0);

    // Min green: EW pulse at tick 2 is latched until tick 4.
    do_reset("ming");
    step(1);
    bus.EW_VEHICLE_DETECT = 1'b1;
    step(1);
    bus.EW_VEHICLE_DETECT = 1'b0;
    expect_state("ming_t2", 0, 2);
    check("ming_ew_req_set", 32'(dut.ew_req_reg), 32'd1);
    step(1); expect_state("ming_t3", 0, 3);
    step(1); expect_state("ming_t4", 1, 0);
    step(5); expect_state("ming_t9", 3, 0);
    check("ming_ew_req_clr", 32'(dut.ew_req_reg), 32'd0);

    // Tick gating mid NS yellow; detectors wiggle with no effect.
    do_reset("gate");
    bus.NS_VEHICLE_DETECT = 1'b1;
    bus.EW_VEHICLE_DETECT = 1'b1;
    step(33); expect_state("gate_t33", 1, 1);
    bus.tick = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.NS_VEHICLE_DETECT = i[0];
      bus.EW_VEHICLE_DETECT = i[1];
      @(posedge clk);
      @(negedge clk);
      check("gate_hold_ns_yellow", 32'(bus.NS_YELLOW), 32'd1);
      check("gate_hold_elapsed", 32'(bus.elapsed), 32'd1);
    end
    expect_state("gate_frozen", 1, 1);
    bus.NS_VEHICLE_DETECT = 1'b1;
    bus.EW_VEHICLE_DETECT = 1'b1;
    step(2); expect_state("gate_resume", 1, 3);
    step(1); expect_state("gate_done", 2, 0);

    // Reset mid EW green at elapsed 7.
    do_reset("ewrst");
    step(37); expect_state("ewrst_t37", 3, 0);
    step(7);  expect_state("ewrst_t44", 3, 7);
    check("ewrst_req_before", 32'(dut.ew_req_reg), 32'd1);
    do_reset("ewrst_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
